// File: rtl/btn_pkg.sv
// Shared definitions for btn_event: the FSM state type and the counter-width helper.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, PRESS, HOLD} btn_state_t;

    // The counter must reach HOLD_CYCLES-2 and REPEAT_CYCLES-1, and it is never narrower than 1 bit.
    function automatic int cnt_w(input int hold, input int rpt);
        int m;
        m = (hold > rpt) ? hold : rpt;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into press/release/click/long/repeat pulses.
// Build option: define BTN_AUTOREPEAT_EN to enable auto-repeat pulses while the button is held.
module btn_event
    import btn_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_lvl,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic long_p,
    output logic rpt_p,
    output logic held
);

    localparam int CW = cnt_w(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 2);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          click_q, click_d;
    logic          long_q, long_d;
    logic          held_q, held_d;
`ifdef BTN_AUTOREPEAT_EN
    logic          rpt_q, rpt_d;
`endif
    logic          p;

    assign p = btn_lvl ^ ACTIVE_LOW;

    // A release always wins over a threshold reached on the same edge, so it is tested first.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (p) begin
                    press_d = 1'b1;
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!p) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!p) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (cnt_q == REPEAT_LAST) begin
                    rpt_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            held_q    <= held_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    assign press_p   = press_q;
    assign release_p = release_q;
    assign click_p   = click_q;
    assign long_p    = long_q;
    assign held      = held_q;
`ifdef BTN_AUTOREPEAT_EN
    assign rpt_p     = rpt_q;
`else
    assign rpt_p     = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event: an active-high instance plus an ACTIVE_LOW=1 instance.
module tb_btn_event;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic btnLvl;
    logic btnLvlInv;

    logic pressP, releaseP, clickP, longP, rptP, heldO;
    logic pressPInv, releasePInv, clickPInv, longPInv, rptPInv, heldInv;

    int checks = 0;
    int errors = 0;
    int pressCnt = 0;
    int releaseCnt = 0;

    always #5 clk = ~clk;

    btn_event #(.ACTIVE_LOW(1'b0), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_lvl(btnLvl),
        .press_p(pressP), .release_p(releaseP), .click_p(clickP),
        .long_p(longP), .rpt_p(rptP), .held(heldO)
    );

    btn_event #(.ACTIVE_LOW(1'b1), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dutInv (
        .clk(clk), .rst_n(rst_n), .btn_lvl(btnLvlInv),
        .press_p(pressPInv), .release_p(releasePInv), .click_p(clickPInv),
        .long_p(longPInv), .rpt_p(rptPInv), .held(heldInv)
    );

    // Expected vectors are packed as {press, release, click, long, rpt, held}.
    function automatic logic [5:0] ev(input logic pr, input logic rl, input logic ck,
                                      input logic lg, input logic rp, input logic hd);
        return {pr, rl, ck, lg, rp, hd};
    endfunction

    task automatic applyStimulus(input logic b, input logic bInv);
        @(negedge clk);
        btnLvl    = b;
        btnLvlInv = bInv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] expd, input logic [5:0] expInv);
        logic [5:0] obs;
        logic [5:0] obsInv;
        obs    = {pressP, releaseP, clickP, longP, rptP, heldO};
        obsInv = {pressPInv, releasePInv, clickPInv, longPInv, rptPInv, heldInv};
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expd);
        end
        checks++;
        assert (obsInv === expInv) else begin
            errors++;
            $error("[TB] FAIL %s_inv: observed=%b expected=%b", tag, obsInv, expInv);
        end
        if (pressP) pressCnt++;
        if (releaseP) releaseCnt++;
        checks++;
        assert ((pressCnt == releaseCnt) || (heldO && pressCnt == releaseCnt + 1)) else begin
            errors++;
            $error("[TB] FAIL %s_balance: observed press=%0d release=%0d held=%b expected balanced",
                   tag, pressCnt, releaseCnt, heldO);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btnLvl    = 1'b0;
        btnLvlInv = 1'b1;
        #2;
        checkOutput("reset", 6'b0, 6'b0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("idle", 6'b0, 6'b0);
        end

        // Short click: held for three edges.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("click_hold", ev(i == 0, 0, 0, 0, 0, 1), 6'b0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("click_rel", ev(0, 1, 1, 0, 0, 0), 6'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("click_after", 6'b0, 6'b0);

        // Long press with repeats, released on edge 20 after the press.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("long_hold",
                        ev(i == 0, 0, 0, i == 7, AUTO && (i == 11 || i == 15 || i == 19), 1), 6'b0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("long_rel", ev(0, 1, 0, 0, 0, 0), 6'b0);

        // Release exactly at the long threshold: click, never long.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("thr_hold", ev(i == 0, 0, 0, 0, 0, 1), 6'b0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("thr_rel", ev(0, 1, 1, 0, 0, 0), 6'b0);

        // Release exactly at a repeat threshold: release only, no repeat.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("rptthr_hold", ev(i == 0, 0, 0, i == 7, 0, 1), 6'b0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("rptthr_rel", ev(0, 1, 0, 0, 0, 0), 6'b0);

        // Asynchronous reset while held in HOLD, button kept pressed.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("rst_hold", ev(i == 0, 0, 0, i == 7, 0, 1), 6'b0);
        end
        rst_n = 1'b0;
        pressCnt   = 0;
        releaseCnt = 0;
        #2;
        checkOutput("rst_async", 6'b0, 6'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_held_low", 6'b0, 6'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("rst_held_low2", 6'b0, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_repress", ev(1, 0, 0, 0, 0, 1), 6'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst_rel", ev(0, 1, 1, 0, 0, 0), 6'b0);

        // Active-low instance: level 0 means pressed.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("alow_hold", 6'b0, ev(i == 0, 0, 0, 0, 0, 1));
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("alow_rel", 6'b0, ev(0, 1, 1, 0, 0, 0));
        applyStimulus(1'b0, 1'b1);
        checkOutput("alow_after", 6'b0, 6'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
